demux_t_s_b: RTL and testbench

//  Receive side of the binary-to-temporal-serial bus. Rebuilds a gamma cycle of NUM_OUTPUTS binary words

---
 rtl/temporal_bus_pkg.sv | 21 ++
 rtl/gamma_slot_counter.sv | 36 +++
 rtl/demux_t_s_b.sv | 90 +++++++++
 tb/tb_demux_t_s_b.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/temporal_bus_pkg.sv
// Shared types and constants for the binary <-> temporal-serial bus.
// Used by both the mux_b_t_s transmitter and the demux_t_s_b receiver.
package temporal_bus_pkg;

  typedef enum logic {
    EDGE_RISING  = 1'b0,
    EDGE_FALLING = 1'b1
  } edge_mode_t;

  localparam int DEFAULT_GAMMA_CYCLE_WIDTH = 16;
  localparam int SLOT_W = $clog2(DEFAULT_GAMMA_CYCLE_WIDTH);

  // Single place that defines which select_line level means "active phase".
  function automatic logic phase_active(
    input edge_mode_t mode,
    input logic       sel
  );
    return (mode == EDGE_FALLING) ? !sel : sel;
  endfunction

endpackage

// File: rtl/gamma_slot_counter.sv
// Slot counter shared by both ends of the temporal-serial bus.
// Advances on request and wraps naturally at WIDTH (a power of two).
module gamma_slot_counter #(
  parameter  int WIDTH = 16,
  localparam int SW    = $clog2(WIDTH)
) (
  input  logic          aclk,
  input  logic          grst,
  input  logic          advance,
  output logic [SW-1:0] count,
  output logic          wrap
);

  logic [SW-1:0] count_q;
  logic [SW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (advance) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge aclk or posedge grst) begin
    if (grst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // wrap marks the edge on which the last slot is left behind.
  assign wrap  = advance && (count_q == SW'(WIDTH - 1));
  assign count = count_q;

endmodule

// File: rtl/demux_t_s_b.sv
// Receive side of the temporal-serial bus: rebuilds a gamma frame of
// binary words and publishes it double-buffered once per counter wrap.
module demux_t_s_b
  import temporal_bus_pkg::*;
#(
  parameter  int         GAMMA_CYCLE_WIDTH = 16,
  parameter  int         NUM_OUTPUTS       = GAMMA_CYCLE_WIDTH,
  parameter  int         BUS_WIDTH         = 4,
  parameter  edge_mode_t EDGE_MODE         = EDGE_RISING,
  localparam int         SW = $clog2(GAMMA_CYCLE_WIDTH)
) (
  input  logic                                  aclk,
  input  logic                                  grst,
  input  logic [BUS_WIDTH-1:0]                  x,
  input  logic                                  select_line,
  output logic [NUM_OUTPUTS-1:0][BUS_WIDTH-1:0] outputs,
  output logic [NUM_OUTPUTS-1:0]                written_mask,
  output logic                                  frame_valid,
  output logic [SW-1:0]                         slot_idx
);

  logic          active;
  logic          wrap;
  logic [SW-1:0] slot;

  logic [NUM_OUTPUTS-1:0][BUS_WIDTH-1:0] shadow_q, shadow_d;
  logic [NUM_OUTPUTS-1:0]                smask_q, smask_d;
  logic [NUM_OUTPUTS-1:0][BUS_WIDTH-1:0] out_q, out_d;
  logic [NUM_OUTPUTS-1:0]                wmask_q, wmask_d;
  logic                                  fv_q, fv_d;

  assign active = phase_active(EDGE_MODE, select_line);

  gamma_slot_counter #(
    .WIDTH   (GAMMA_CYCLE_WIDTH)
  ) u_cnt (
    .aclk    (aclk),
    .grst    (grst),
    .advance (!active),
    .count   (slot),
    .wrap    (wrap)
  );

  // Capture is active-only and commit inactive-only, so they never collide.
  always_comb begin
    shadow_d = shadow_q;
    smask_d  = smask_q;
    if (active) begin
      shadow_d[slot] = x;
      smask_d[slot]  = 1'b1;
    end else if (wrap) begin
      shadow_d = '0;
      smask_d  = '0;
    end
  end

  always_comb begin
    out_d   = out_q;
    wmask_d = wmask_q;
    fv_d    = wrap;
    if (wrap) begin
      wmask_d = smask_q;
      for (int i = 0; i < NUM_OUTPUTS; i++) begin
        out_d[i] = smask_q[i] ? shadow_q[i] : '0;
      end
    end
  end

  always_ff @(posedge aclk or posedge grst) begin
    if (grst) begin
      shadow_q <= '0;
      smask_q  <= '0;
      out_q    <= '0;
      wmask_q  <= '0;
      fv_q     <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      smask_q  <= smask_d;
      out_q    <= out_d;
      wmask_q  <= wmask_d;
      fv_q     <= fv_d;
    end
  end

  assign outputs      = out_q;
  assign written_mask = wmask_q;
  assign frame_valid  = fv_q;
  assign slot_idx     = slot;

endmodule

// File: tb/tb_demux_t_s_b.sv
// Scoreboard bench for demux_t_s_b: a rising and a falling instance
// are fed the same traffic; a reference model predicts each frame.
module tb_demux_t_s_b;
  import temporal_bus_pkg::*;

  localparam int G  = 16;
  localparam int BW = 4;

  logic                 aclk = 1'b0;
  logic                 grst;
  logic [BW-1:0]        x;
  logic                 sel_r, sel_f;
  logic [G-1:0][BW-1:0] out_r, out_f;
  logic [G-1:0]         wm_r, wm_f;
  logic                 fv_r, fv_f;
  logic [3:0]           si_r, si_f;

  always #5 aclk = ~aclk;

  demux_t_s_b #(
    .GAMMA_CYCLE_WIDTH (G),
    .BUS_WIDTH         (BW),
    .EDGE_MODE         (EDGE_RISING)
  ) dut_r (
    .aclk         (aclk),
    .grst         (grst),
    .x            (x),
    .select_line  (sel_r),
    .outputs      (out_r),
    .written_mask (wm_r),
    .frame_valid  (fv_r),
    .slot_idx     (si_r)
  );

  demux_t_s_b #(
    .GAMMA_CYCLE_WIDTH (G),
    .BUS_WIDTH         (BW),
    .EDGE_MODE         (EDGE_FALLING)
  ) dut_f (
    .aclk         (aclk),
    .grst         (grst),
    .x            (x),
    .select_line  (sel_f),
    .outputs      (out_f),
    .written_mask (wm_f),
    .frame_valid  (fv_f),
    .slot_idx     (si_f)
  );

  typedef struct packed {
    logic [63:0] o;
    logic [15:0] m;
  } frame_t;

  frame_t      sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic [63:0] cur_o = '0;
  logic [15:0] cur_m = '0;
  logic        exp_fv = 1'b0;
  int          m_cnt = 0;
  logic [3:0]  m_sh[G];
  logic [15:0] m_mk = '0;
  int          pulses = 0;
  int          last_pulse = -1;
  logic        track = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_cnt = 0;
    m_mk  = '0;
    for (int i = 0; i < G; i++) m_sh[i] = '0;
  endtask

  // One bus cycle: act=1 drives an active phase carrying d.
  task automatic step(input bit act, input logic [3:0] d);
    frame_t f;
    bit     pushed;
    pushed = 1'b0;
    x      = d;
    sel_r  = act;
    sel_f  = !act;
    if (act) begin
      m_sh[m_cnt] = d;
      m_mk[m_cnt] = 1'b1;
    end else begin
      if (m_cnt == G - 1) begin
        f.m = m_mk;
        for (int i = 0; i < G; i++)
          f.o[i*4 +: 4] = m_mk[i] ? m_sh[i] : 4'h0;
        sb.push_back(f);
        pushed = 1'b1;
        m_mk   = '0;
        for (int i = 0; i < G; i++) m_sh[i] = '0;
      end
      m_cnt = (m_cnt + 1) % G;
    end
    @(posedge aclk);
    #1;
    exp_fv = pushed;
    chk("slot_r", 64'(si_r), 64'(m_cnt));
    chk("slot_f", 64'(si_f), 64'(m_cnt));
  endtask

  task automatic full_frame(input int skip_a, input int skip_b);
    for (int i = 0; i < G; i++) begin
      if (i != skip_a && i != skip_b) step(1'b1, 4'($urandom_range(0, 15)));
      step(1'b0, 4'h0);
    end
  endtask

  task automatic do_reset();
    grst   = 1'b1;
    cur_o  = '0;
    cur_m  = '0;
    exp_fv = 1'b0;
    sb.delete();
    model_clear();
    #1;
    chk("rst_out_r", 64'(out_r), 64'h0);
    chk("rst_out_f", 64'(out_f), 64'h0);
    chk("rst_mask", 64'({wm_r, wm_f}), 64'h0);
    chk("rst_fv", 64'({fv_r, fv_f}), 64'h0);
    chk("rst_slot", 64'({si_r, si_f}), 64'h0);
    repeat (2) @(posedge aclk);
    #1;
    grst = 1'b0;
  endtask

  always @(posedge aclk) cyc <= cyc + 1;

  always @(negedge aclk) begin
    chk("fv_r", 64'(fv_r), 64'(exp_fv));
    chk("fv_f", 64'(fv_f), 64'(exp_fv));
    if (exp_fv) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 64'h1, 64'h0);
      end else begin
        frame_t f;
        f     = sb.pop_front();
        cur_o = f.o;
        cur_m = f.m;
      end
    end
    if (fv_r) begin
      if (track && last_pulse >= 0) chk("gap", 64'(cyc - last_pulse), 64'd16);
      last_pulse = cyc;
      pulses++;
    end
    chk("out_r", 64'(out_r), cur_o);
    chk("out_f", 64'(out_f), cur_o);
    chk("mask_r", 64'(wm_r), 64'(cur_m));
    chk("mask_f", 64'(wm_f), 64'(cur_m));
  end

  initial begin
    grst  = 1'b0;
    x     = '0;
    sel_r = 1'b0;
    sel_f = 1'b1;
    model_clear();
    #1;
    do_reset();

    // 1: slot i carries i
    for (int i = 0; i < G; i++) begin
      step(1'b1, 4'(i));
      step(1'b0, 4'h0);
    end
    @(negedge aclk);
    #1;
    chk("t1_out", 64'(out_r), 64'hFEDCBA9876543210);
    chk("t1_mask", 64'(wm_r), 64'hFFFF);

    // 2: slot i carries 15-i
    for (int i = 0; i < G; i++) begin
      step(1'b1, 4'(15 - i));
      step(1'b0, 4'h0);
    end
    @(negedge aclk);
    #1;
    chk("t2_out_f", 64'(out_f), 64'h0123456789ABCDEF);

    // 3: slots 3 and 9 skipped
    full_frame(3, 9);
    @(negedge aclk);
    #1;
    chk("t3_mask", 64'(wm_r), 64'hFDF7);
    chk("t3_o3", 64'(out_r[3]), 64'h0);
    chk("t3_o9", 64'(out_r[9]), 64'h0);

    // 4: slot 5 written three times
    for (int i = 0; i < G; i++) begin
      if (i == 5) begin
        step(1'b1, 4'h2);
        step(1'b1, 4'h7);
        step(1'b1, 4'hA);
      end else begin
        step(1'b1, 4'(i));
      end
      step(1'b0, 4'h0);
    end
    @(negedge aclk);
    #1;
    chk("t4_o5", 64'(out_r[5]), 64'hA);

    // 5: reset at slot 8, then a clean frame
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 4'(i + 1));
      step(1'b0, 4'h0);
    end
    step(1'b1, 4'h3);
    do_reset();
    full_frame(-1, -1);
    @(negedge aclk);
    #1;
    chk("t5_mask", 64'(wm_r), 64'hFFFF);

    // 6: inactive only
    track      = 1'b1;
    pulses     = 0;
    last_pulse = -1;
    repeat (48) step(1'b0, 4'h0);
    @(negedge aclk);
    #1;
    chk("t6_pulses", 64'(pulses), 64'd3);
    chk("t6_out", 64'(out_r), 64'h0);
    chk("t6_mask", 64'(wm_r), 64'h0);
    track = 1'b0;

    @(posedge aclk);
    #1;
    chk("sb_empty", 64'(sb.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
